// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - CPU clock generator with free-run and debounced single-step modes
//
// Generates a slow, registered CPU clock for a downstream mother board.
// In free-run mode the clock is a 50% duty square wave at a selectable rate.
// In single-step mode each debounced press of the step button yields exactly
// one high pulse of half-period length.
//
// Ports:
//   clock      in   1  board clock, all state updates on its rising edge
//   reset      in   1  synchronous, active-high
//   run_mode   in   1  async slide switch: 1 = free-run, 0 = single-step
//   speed      in   2  free-run rate: 00 = 1 Hz, 01 = 2 Hz, 10 = 10 Hz, 11 = 100 Hz
//   step_btn   in   1  async raw push button, active-high, may bounce
//   cpu_clock  out  1  registered CPU clock level
//   cpu_tick   out  1  one-cycle pulse in the cycle cpu_clock rises
//   step_count out  8  cpu_tick pulses since reset, wraps 255 -> 0
//
// Build option:
//   CPU_CLOCK_CTRL_STEP_COUNT_EN  when defined, step_count counts cpu_tick
//                                 pulses; otherwise it is tied to zero.

`timescale 1ns / 1ps

module cpu_clock_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run_mode,
    input  logic [1:0] speed,
    input  logic       step_btn,
    output logic       cpu_clock,
    output logic       cpu_tick,
    output logic [7:0] step_count
);

    // Half-period lengths in board cycles, never below one cycle.
    localparam int HALF_1HZ   = (CLK_HZ / 2   < 1) ? 1 : CLK_HZ / 2;
    localparam int HALF_2HZ   = (CLK_HZ / 4   < 1) ? 1 : CLK_HZ / 4;
    localparam int HALF_10HZ  = (CLK_HZ / 20  < 1) ? 1 : CLK_HZ / 20;
    localparam int HALF_100HZ = (CLK_HZ / 200 < 1) ? 1 : CLK_HZ / 200;

    // The 1 Hz half period is the longest, so it sizes the counter.
    localparam int CNT_W = $clog2(HALF_1HZ + 1);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_1HZ   = CNT_W'(HALF_1HZ - 1);
    localparam logic [CNT_W-1:0] LAST_2HZ   = CNT_W'(HALF_2HZ - 1);
    localparam logic [CNT_W-1:0] LAST_10HZ  = CNT_W'(HALF_10HZ - 1);
    localparam logic [CNT_W-1:0] LAST_100HZ = CNT_W'(HALF_100HZ - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STEP_IDLE,
        STEP_HIGH,
        RUN_LOW,
        RUN_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic       r_run_meta;
    logic       r_run_sync;
    logic       r_btn_meta;
    logic       r_btn_sync;
    logic [1:0] r_sync_warm;
    logic       w_sync_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_run_meta  <= 1'b0;
            r_run_sync  <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
            r_sync_warm <= 2'b00;
        end else begin
            r_run_meta  <= run_mode;
            r_run_sync  <= r_run_meta;
            r_btn_meta  <= step_btn;
            r_btn_sync  <= r_btn_meta;
            r_sync_warm <= {r_sync_warm[0], 1'b1};
        end
    end

    // The synchronizer outputs only reflect the real pins once the cleared
    // reset values have been flushed out of both stages.
    assign w_sync_valid = r_sync_warm[1];

    // ------------------------------------------------------------------
    // Button debounce and step request
    // ------------------------------------------------------------------
    logic            r_db_level;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_btn_armed;
    logic            r_step_req;
    logic            w_btn_differs;
    logic            w_db_accept;

    assign w_btn_differs = (r_btn_sync != r_db_level);
    assign w_db_accept   = w_btn_differs && (r_db_cnt == DB_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_db_level  <= 1'b0;
            r_db_cnt    <= '0;
            r_btn_armed <= 1'b0;
            r_step_req  <= 1'b0;
        end else begin
            if (!w_btn_differs) begin
                r_db_cnt <= '0;
            end else if (w_db_accept) begin
                r_db_cnt   <= '0;
                r_db_level <= r_btn_sync;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end

            // A button held through reset must be seen released before a
            // press can count, so requests are blocked until a genuine low.
            r_btn_armed <= r_btn_armed | (w_sync_valid & ~r_btn_sync);
            r_step_req  <= w_db_accept & r_btn_sync & r_btn_armed;
        end
    end

    // ------------------------------------------------------------------
    // Clock generator FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_half_cnt;
    logic [CNT_W-1:0] w_half_cnt_next;
    logic [CNT_W-1:0] w_half_last;
    logic             w_phase_done;
    logic             w_next_high;
    logic             r_cpu_clock;
    logic             r_cpu_tick;

    always_comb begin
        w_half_last = LAST_1HZ;
        case (speed)
            2'b00:   w_half_last = LAST_1HZ;
            2'b01:   w_half_last = LAST_2HZ;
            2'b10:   w_half_last = LAST_10HZ;
            default: w_half_last = LAST_100HZ;
        endcase
    end

    // ">=" rather than "==" lets a speed change to a shorter half period
    // end the current phase on the very next cycle.
    assign w_phase_done = (r_half_cnt >= w_half_last);

    always_comb begin
        w_state_next    = r_state;
        w_half_cnt_next = r_half_cnt;
        case (r_state)
            STEP_IDLE: begin
                w_half_cnt_next = '0;
                if (r_run_sync) begin
                    w_state_next = RUN_LOW;
                end else if (r_step_req) begin
                    w_state_next = STEP_HIGH;
                end
            end
            STEP_HIGH: begin
                // Requests are not looked at here, so presses are dropped.
                if (w_phase_done) begin
                    w_half_cnt_next = '0;
                    w_state_next    = r_run_sync ? RUN_LOW : STEP_IDLE;
                end else begin
                    w_half_cnt_next = r_half_cnt + 1'b1;
                end
            end
            RUN_LOW: begin
                if (!r_run_sync) begin
                    w_half_cnt_next = '0;
                    w_state_next    = STEP_IDLE;
                end else if (w_phase_done) begin
                    w_half_cnt_next = '0;
                    w_state_next    = RUN_HIGH;
                end else begin
                    w_half_cnt_next = r_half_cnt + 1'b1;
                end
            end
            RUN_HIGH: begin
                if (!r_run_sync) begin
                    w_half_cnt_next = '0;
                    w_state_next    = STEP_IDLE;
                end else if (w_phase_done) begin
                    w_half_cnt_next = '0;
                    w_state_next    = RUN_LOW;
                end else begin
                    w_half_cnt_next = r_half_cnt + 1'b1;
                end
            end
            default: begin
                w_half_cnt_next = '0;
                w_state_next    = STEP_IDLE;
            end
        endcase
    end

    assign w_next_high = (w_state_next == STEP_HIGH) || (w_state_next == RUN_HIGH);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= STEP_IDLE;
            r_half_cnt  <= '0;
            r_cpu_clock <= 1'b0;
            r_cpu_tick  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_half_cnt  <= w_half_cnt_next;
            r_cpu_clock <= w_next_high;
            r_cpu_tick  <= w_next_high & ~r_cpu_clock;
        end
    end

    assign cpu_clock = r_cpu_clock;
    assign cpu_tick  = r_cpu_tick;

    // ------------------------------------------------------------------
    // Step counter
    // ------------------------------------------------------------------
`ifdef CPU_CLOCK_CTRL_STEP_COUNT_EN
    logic [7:0] r_step_count;

    // Updated on the same edge that raises cpu_tick, so the count already
    // includes the pulse currently on cpu_tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_step_count <= 8'd0;
        end else if (w_next_high & ~r_cpu_clock) begin
            r_step_count <= r_step_count + 8'd1;
        end
    end

    assign step_count = r_step_count;
`else
    assign step_count = 8'd0;
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb/tb_cpu_clock_ctrl.sv - randomized self-checking bench for cpu_clock_ctrl

`timescale 1ns / 1ps

module tb_cpu_clock_ctrl;

    localparam int CLK_HZ = 400;
    localparam int DB     = 8;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       run_mode = 1'b0;
    logic [1:0] speed    = 2'b00;
    logic       step_btn = 1'b0;
    logic       cpu_clock;
    logic       cpu_tick;
    logic [7:0] step_count;

    int n_cmp     = 0;
    int n_err     = 0;
    int obs_ticks = 0;
    int obs_high  = 0;

    // Reference model: timestamps of phase starts instead of counters.
    int m_t      = 0;
    int m_pstart = 0;
    int m_count  = 0;
    bit m_run    = 0;
    bit m_hi     = 0;
    bit m_tick   = 0;
    bit m_run_m  = 0, m_run_s = 0, m_btn_m = 0, m_btn_s = 0, m_vm = 0, m_vs = 0;
    bit m_level  = 0, m_armed = 0, m_req = 0;
    bit m_win[$];

    cpu_clock_ctrl #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run_mode   (run_mode),
        .speed      (speed),
        .step_btn   (step_btn),
        .cpu_clock  (cpu_clock),
        .cpu_tick   (cpu_tick),
        .step_count (step_count)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int half_of(input logic [1:0] sp);
        int f;
        int h;
        case (sp)
            2'b00:   f = 1;
            2'b01:   f = 2;
            2'b10:   f = 10;
            default: f = 100;
        endcase
        h = CLK_HZ / (2 * f);
        return (h < 1) ? 1 : h;
    endfunction

    function automatic logic [7:0] exp_count();
`ifdef CPU_CLOCK_CTRL_STEP_COUNT_EN
        return 8'(m_count);
`else
        return 8'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rs, bs, vs, req, same, acc, old_hi;
        int len;
        int h;
        if (reset) begin
            m_run = 0; m_hi = 0; m_tick = 0; m_count = 0; m_pstart = m_t;
            m_run_m = 0; m_run_s = 0; m_btn_m = 0; m_btn_s = 0; m_vm = 0; m_vs = 0;
            m_level = 0; m_armed = 0; m_req = 0;
            m_win.delete();
            for (int i = 0; i < DB; i++) m_win.push_back(1'b0);
        end else begin
            rs = m_run_s; bs = m_btn_s; vs = m_vs; req = m_req;

            // Debounce: accept when the last DB synced samples all agree
            // and differ from the current level.
            m_win.push_back(bs);
            void'(m_win.pop_front());
            same = 1;
            foreach (m_win[i]) if (m_win[i] != bs) same = 0;
            acc   = same && (bs != m_level);
            m_req = acc && bs && m_armed;
            if (acc) m_level = bs;
            if (vs && !bs) m_armed = 1;

            // Clock: a phase lasts HALF cycles measured from its start edge.
            len    = m_t - m_pstart;
            h      = half_of(speed);
            old_hi = m_hi;
            if (m_run) begin
                if (!rs) begin
                    m_run = 0; m_hi = 0;
                end else if (len >= h) begin
                    m_hi = !m_hi; m_pstart = m_t;
                end
            end else if (m_hi) begin
                if (len >= h) begin
                    m_hi = 0; m_pstart = m_t;
                    if (rs) m_run = 1;
                end
            end else begin
                if (rs) begin
                    m_run = 1; m_pstart = m_t;
                end else if (req) begin
                    m_hi = 1; m_pstart = m_t;
                end
            end
            m_tick = m_hi && !old_hi;
            if (m_tick) m_count = (m_count + 1) % 256;

            m_run_s = m_run_m; m_run_m = run_mode;
            m_btn_s = m_btn_m; m_btn_m = step_btn;
            m_vs    = m_vm;    m_vm    = 1;
        end
        m_t++;
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check($sformatf("cycle%0d {clk,tick,count}", m_t),
              {22'd0, cpu_clock, cpu_tick, step_count},
              {22'd0, m_hi, m_tick, exp_count()});
        obs_ticks += int'(cpu_tick);
        obs_high  += int'(cpu_clock);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    int n;
    int len;
    int mode;

    initial begin
        // Reset state
        reset = 1'b1;
        run(2);
        check("reset_cpu_clock", {31'd0, cpu_clock}, 32'd0);
        check("reset_cpu_tick", {31'd0, cpu_tick}, 32'd0);
        check("reset_step_count", {24'd0, step_count}, 32'd0);
        reset = 1'b0;

        // Free-run at 100 Hz: period 4, high 2, ten ticks
        run_mode = 1'b1; speed = 2'b11;
        obs_ticks = 0; obs_high = 0;
        run(42);
        check("run100_ticks", obs_ticks, 10);
        check("run100_high_cycles", obs_high, 20);
`ifdef CPU_CLOCK_CTRL_STEP_COUNT_EN
        check("run100_step_count", {24'd0, step_count}, 32'd10);
`else
        check("run100_step_count", {24'd0, step_count}, 32'd0);
`endif
        run_mode = 1'b0;
        run(10);

        // Bouncing press followed by a stable press: exactly one step
        speed = 2'b00;
        obs_ticks = 0; obs_high = 0;
        for (int i = 0; i < 300; i++) begin
            if (i < 30)      step_btn = 1'((i / 3) % 2);
            else if (i < 50) step_btn = 1'b1;
            else             step_btn = 1'b0;
            cyc();
        end
        check("bounce_ticks", obs_ticks, 1);
        check("bounce_high_cycles", obs_high, 200);

        // Second press during the high phase is dropped
        obs_ticks = 0; obs_high = 0;
        for (int i = 0; i < 260; i++) begin
            step_btn = (i < 12) || (i >= 32 && i < 44);
            cyc();
        end
        check("double_press_ticks", obs_ticks, 1);
        check("double_press_high", obs_high, 200);

        // Speed change late in a 1 Hz high phase
        run_mode = 1'b1; speed = 2'b00;
        n = 0;
        while (!cpu_tick && n < 400) begin cyc(); n++; end
        check("slow_rise_seen", {31'd0, cpu_tick}, 32'd1);
        run(150);
        speed = 2'b10;
        cyc();
        check("fast_fall_next", {31'd0, cpu_clock}, 32'd0);
        n = 0;
        while (!cpu_tick && n < 100) begin cyc(); n++; end
        check("fast_rise_seen", {31'd0, cpu_tick}, 32'd1);
        n = 0;
        do begin cyc(); n++; end while (!cpu_tick && n < 100);
        check("fast_period", n, 40);

        // Leaving free-run during a high phase
        run_mode = 1'b0;
        run(3);
        check("stop_within_3", {31'd0, cpu_clock}, 32'd0);
        obs_ticks = 0;
        run(50);
        check("no_tick_after_stop", obs_ticks, 0);

        // Reset in the middle of a run once the count reaches 255
        run_mode = 1'b1; speed = 2'b11;
        n = 0;
        while (m_count != 255 && n < 3000) begin cyc(); n++; end
        check("reach_255", {31'd0, cpu_clock}, 32'd1);
`ifdef CPU_CLOCK_CTRL_STEP_COUNT_EN
        check("count_255", {24'd0, step_count}, 32'd255);
`else
        check("count_255", {24'd0, step_count}, 32'd0);
`endif
        reset = 1'b1;
        cyc();
        check("midrun_reset_outputs", {22'd0, cpu_clock, cpu_tick, step_count}, 32'd0);
        reset = 1'b0; run_mode = 1'b0;
        run(5);

        // Button held through reset must be released before it steps
        step_btn = 1'b1; reset = 1'b1;
        run(2);
        reset = 1'b0;
        obs_ticks = 0;
        run(40);
        check("held_through_reset", obs_ticks, 0);
        step_btn = 1'b0; run(20);
        step_btn = 1'b1; run(20);
        step_btn = 1'b0; run(20);
        check("press_after_release", obs_ticks, 1);

        // Randomized mix of modes, speeds, bouncing and resets
        for (int s = 0; s < 50; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                run(1 + int'($urandom_range(0, 1)));
                reset = 1'b0;
            end
            run_mode = 1'($urandom_range(0, 1));
            speed = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1))
                                                : 2'($urandom_range(2, 3));
            mode = int'($urandom_range(0, 3));
            len  = int'($urandom_range(20, 250));
            for (int i = 0; i < len; i++) begin
                case (mode)
                    0:       step_btn = 1'b0;
                    1:       step_btn = (i >= len / 2);
                    2:       step_btn = (i < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
                    default: if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
                endcase
                if ($urandom_range(0, 99) == 0) speed = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 149) == 0) run_mode = ~run_mode;
                cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_clock_ctrl.md
CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, board clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable samples required to accept a step_btn level.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port run_mode, input, 1, asynchronous slide switch; 1 = free-run, 0 = single-step.
REQ-006 SHALL have port speed, input, 2, free-run rate select: 00 = 1 Hz, 01 = 2 Hz, 10 = 10 Hz, 11 = 100 Hz.
REQ-007 SHALL have port step_btn, input, 1, asynchronous raw push button, active-high, may bounce.
REQ-008 SHALL have port cpu_clock, output, 1, registered CPU clock level for downstream mother_board.
REQ-009 SHALL have port cpu_tick, output, 1, one-cycle pulse coincident with each cpu_clock rising edge.
REQ-010 SHALL have port step_count, output, 8, number of cpu_tick pulses since reset.

Function
REQ-011 SHALL pass run_mode and step_btn through 2-flop synchronizers before any use.
REQ-012 SHALL accept a new debounced button level only after DEBOUNCE_CYCLES consecutive equal synchronized samples; any differing sample restarts the count.
REQ-013 SHALL produce one step request per debounced 0->1 transition; releases and held levels produce none.
REQ-014 SHALL define HALF = CLK_HZ/(2*f) cycles for the selected f, integer division, minimum 1.
REQ-015 SHALL implement FSM states STEP_IDLE, STEP_HIGH, RUN_LOW, RUN_HIGH.
REQ-016 STEP_IDLE: cpu_clock=0; a step request goes to STEP_HIGH; synchronized run_mode=1 goes to RUN_LOW.
REQ-017 STEP_HIGH: cpu_clock=1 for exactly HALF cycles, then returns to STEP_IDLE; step requests arriving here are dropped, not queued.
REQ-018 RUN_LOW/RUN_HIGH: a half-period counter alternates the states every HALF cycles, giving a 50% duty square wave.
REQ-019 cpu_tick SHALL be 1 in exactly the cycle cpu_clock changes 0->1 and 0 otherwise.
REQ-020 A speed change SHALL take effect at the next counter comparison; if the counter already is >= new HALF-1, the toggle SHALL occur on the next cycle.
REQ-021 Synchronized run_mode 1->0 in any RUN state SHALL go to STEP_IDLE the next cycle, forcing cpu_clock=0 and clearing the counter.
REQ-022 Synchronized run_mode 0->1 in STEP_HIGH SHALL complete the high phase, then enter RUN_LOW with the counter cleared.
REQ-023 Step requests while run_mode=1 SHALL be ignored.
REQ-024 step_count SHALL increment on every cpu_tick and wrap 255->0.

Reset
REQ-025 Reset SHALL put the FSM in STEP_IDLE, clear all counters and synchronizers, set the debounced level to 0, and drive cpu_clock=0, cpu_tick=0, step_count=0 in the cycle after it is sampled high.
REQ-026 Reset asserted mid-phase SHALL abort the phase with no cpu_tick; a button held across reset SHALL not produce a step until released and pressed again.

Configuration
REQ-027 With CPU_CLOCK_CTRL_STEP_COUNT_EN defined, step_count SHALL behave per REQ-024.
REQ-028 Without CPU_CLOCK_CTRL_STEP_COUNT_EN, step_count SHALL be tied to constant 0 and no counter logic SHALL exist; all other behaviour SHALL be unchanged.

Verification (CLK_HZ=400, DEBOUNCE_CYCLES=8; HALF = 200/100/20/2)
REQ-029 Reset, run_mode=1, speed=11 -> cpu_clock period 4 cycles, high for 2; one cpu_tick per period; step_count=10 after 10 periods.
REQ-030 run_mode=0, step_btn bouncing 0/1 every 3 cycles for 30 cycles, then stable 1 for 20 -> exactly one cpu_tick; cpu_clock high for 200 cycles at speed=00.
REQ-031 STEP mode, second clean press during STEP_HIGH -> ignored; exactly 1 cpu_tick in total.
REQ-032 RUN at speed=00, counter at 150 in RUN_HIGH, switch to speed=10 -> cpu_clock falls on the next cycle; the following periods are 40 cycles.
REQ-033 run_mode 1->0 during RUN_HIGH -> cpu_clock=0 within 3 cycles (sync + 1); no further cpu_tick without a press.
REQ-034 Reset pulsed mid-RUN with step_count=255 defined -> all outputs 0; without the macro, step_count stays 0 throughout.
